// File: rtl/im_loader.sv
// Program-load writer: assembles a little-endian byte stream into 32-bit words for the instruction store.
// Optional trailer checksum check is enabled with `define LOADER_CHECKSUM_EN.
module im_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          DEPTH     = 1024,
    parameter int          LW        = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [LW-1:0] len_words,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          we,
    output logic [31:0]   waddr,
    output logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] word_count,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

    localparam logic [LW-1:0] DEPTH_W = LW'(DEPTH);

    state_t        state_reg, state_next;
    logic [LW-1:0] len_reg;
    logic [LW-1:0] word_count_reg;
    logic [LW-1:0] word_count_inc;
    logic [LW-1:0] len_clamped;
    logic [1:0]    byte_cnt_reg;
    logic          xfer;

    assign len_clamped    = (len_words > DEPTH_W) ? DEPTH_W : len_words;
    assign word_count_inc = word_count_reg + LW'(1);
    assign xfer           = byte_valid & byte_ready;
    assign word_count     = word_count_reg;
    // Address is derived from the word counter, so it can never run past the clamped length.
    assign waddr          = BASE_ADDR + (32'(word_count_reg) << 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        byte_ready = 1'b0;
        busy       = 1'b0;
        we         = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (len_clamped == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && byte_cnt_reg == 2'd3) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                we   = 1'b1;
                busy = 1'b1;
                if (word_count_inc == len_reg) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = CSUM;
`else
                    state_next = DONE;
`endif
                end else begin
                    state_next = RECV;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && byte_cnt_reg == 2'd3) begin
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_reg        <= '0;
            word_count_reg <= '0;
            byte_cnt_reg   <= '0;
        end else begin
            if (state_reg == IDLE && start) begin
                len_reg        <= len_clamped;
                word_count_reg <= '0;
                byte_cnt_reg   <= '0;
            end else begin
                if (xfer) begin
                    byte_cnt_reg <= byte_cnt_reg + 2'd1;
                end
                if (state_reg == WRITE) begin
                    word_count_reg <= word_count_inc;
                end
            end
        end
    end

    // One register per byte lane; the lane selected by the byte counter captures the stream byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    lane_reg <= '0;
                end else if (xfer && byte_cnt_reg == 2'(gi)) begin
                    lane_reg <= byte_data;
                end
            end
            assign wdata[8*gi +: 8] = lane_reg;
        end
    endgenerate

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_reg;
    logic        err_reg;

    // The trailer reuses the byte lanes; its top byte is compared straight off the stream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && start) begin
                sum_reg <= '0;
                err_reg <= 1'b0;
            end else if (state_reg == WRITE) begin
                sum_reg <= sum_reg + wdata;
            end else if (state_reg == CSUM && xfer && byte_cnt_reg == 2'd3) begin
                err_reg <= ({byte_data, wdata[23:0]} != sum_reg);
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: stimulus pushes expected writes, a negedge monitor pops and compares.
// Checksum vectors are exercised only when LOADER_CHECKSUM_EN is defined.
module tb_im_loader;

    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len_words = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready;
    logic          we;
    logic [31:0]   waddr;
    logic [31:0]   wdata;
    logic          busy;
    logic          done;
    logic [LW-1:0] word_count;
    logic          err;

    im_loader #(.BASE_ADDR(32'h0000_3000), .DEPTH(1024), .LW(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .len_words(len_words),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done),
        .word_count(word_count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          we_count = 0;
    int          last_we_cyc = 0;
    int          done_cyc = 0;
    logic [31:0] last_waddr = '0;
    logic        ready_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (byte_ready) ready_seen = 1'b1;

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && we) begin
            wr_t e;
            we_count++;
            last_waddr  = waddr;
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: waddr 0x%08h wdata 0x%08h, expected no write", waddr, wdata);
            end else begin
                e = exp_q.pop_front();
                check("waddr", waddr, e.addr);
                check("wdata", wdata, e.data);
                $display("write 0x%08h <= 0x%08h", waddr, wdata);
            end
        end
    end

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic start_load(input logic [LW-1:0] n);
        start     = 1'b1;
        len_words = n;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        forever begin
            @(negedge clk);
            if (byte_ready) break;
            n++;
            if (n > 50) begin
                check("byte_accept_timeout", 32'(byte_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            if (gaps) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_done(input int budget, output int waited);
        waited = 0;
        forever begin
            @(negedge clk);
            waited++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (waited >= budget) begin
                check("done_timeout", 32'(done), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          wc0;
        logic [31:0] word;

        // Reset state, checked while reset is still asserted.
        #12;
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_waddr", waddr, 32'h0000_3000);
        check("rst_wdata", wdata, 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic two-word load, bytes back to back.
        push_exp(32'h0000_3000, 32'h1234_5678);
        push_exp(32'h0000_3004, 32'hDEAD_BEEF);
        start_load(11'd2);
        check("t1_busy", 32'(busy), 32'd1);
        send_word(32'h1234_5678, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        wait_done(20, w);
        check("t1_done_after_write", 32'(done_cyc - last_we_cyc), 32'd1);
        check("t1_word_count", 32'(word_count), 32'd2);
        check("t1_queue_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: valid toggles each cycle.
        push_exp(32'h0000_3000, 32'h4433_2211);
        start_load(11'd1);
        send_word(32'h4433_2211, 1'b1);
        wait_done(20, w);
        check("t2_word_count", 32'(word_count), 32'd1);
        check("t2_queue_drained", 32'(exp_q.size()), 32'd0);

        // Empty load.
        wc0 = we_count;
        ready_seen = 1'b0;
        start_load(11'd0);
        wait_done(10, w);
        check("t3_done_latency_ok", 32'(w >= 1 && w <= 2), 32'd1);
        check("t3_no_write", 32'(we_count - wc0), 32'd0);
        check("t3_no_ready", 32'(ready_seen), 32'd0);
        check("t3_word_count", 32'(word_count), 32'd0);

        // Clamp: 1500 requested, 1024 written.
        wc0 = we_count;
        start_load(11'd1500);
        for (int i = 0; i < 1024; i++) begin
            word = 32'(i) * 32'h9E37_79B9;
            push_exp(32'h0000_3000 + 32'(i) * 32'd4, word);
            send_word(word, 1'b0);
        end
        wait_done(20, w);
        check("t4_write_count", 32'(we_count - wc0), 32'd1024);
        check("t4_last_waddr", last_waddr, 32'h0000_3FFC);
        check("t4_word_count", 32'(word_count), 32'd1024);
        ready_seen = 1'b0;
        wc0 = we_count;
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        repeat (6) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        check("t4_post_done_no_ready", 32'(ready_seen), 32'd0);
        check("t4_post_done_no_write", 32'(we_count - wc0), 32'd0);

        // Async reset after the 2nd byte of word 3.
        start_load(11'd4);
        for (int i = 0; i < 3; i++) begin
            push_exp(32'h0000_3000 + 32'(i) * 32'd4, 32'hA0B0_C000 + 32'(i));
            send_word(32'hA0B0_C000 + 32'(i), 1'b0);
        end
        send_byte(8'h01);
        send_byte(8'h02);
        #2;
        reset = 1'b1;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_byte_ready", 32'(byte_ready), 32'd0);
        check("t5_we", 32'(we), 32'd0);
        check("t5_waddr", waddr, 32'h0000_3000);
        check("t5_wdata", wdata, 32'd0);
        check("t5_word_count", 32'(word_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t5_queue_drained", 32'(exp_q.size()), 32'd0);
        push_exp(32'h0000_3000, 32'hCAFE_F00D);
        start_load(11'd1);
        send_word(32'hCAFE_F00D, 1'b0);
        wait_done(20, w);
        check("t5_reload_word_count", 32'(word_count), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Checksum trailer, good then bad.
        push_exp(32'h0000_3000, 32'd1);
        push_exp(32'h0000_3004, 32'd2);
        start_load(11'd2);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd3, 1'b0);
        wait_done(20, w);
        check("t6_err_good", 32'(err), 32'd0);
        push_exp(32'h0000_3000, 32'd1);
        push_exp(32'h0000_3004, 32'd2);
        start_load(11'd2);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd4, 1'b0);
        wait_done(20, w);
        check("t6_err_bad", 32'(err), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t6_err_held", 32'(err), 32'd1);
        start_load(11'd0);
        check("t6_err_cleared", 32'(err), 32'd0);
        wait_done(10, w);
`endif

        check("final_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
